serpent_round_ctrl: RTL and testbench
=====================================

Name: serpent_round_ctrl

Overview:
Iterative Serpent encryption sequencer. Owns the 128-bit block state register and the round counter. Each round it fetches one subkey from the key schedule, XORs it into the state, and presents the result with the round index to the external combinational round function (S-box plus linear transform stage). After round 31 it fetches K32 for the output whitening XOR and returns the ciphertext over a valid/ready handshake.

Parameters:
ROUNDS, 32, number of S-box rounds; subkeys K0..K(ROUNDS) are used.
IDX_W, 6, width of the round and key index buses.

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-high reset
i_valid  in  1  plaintext block offered
o_ready  out  1  controller accepts a block
i_data  in  128  plaintext
o_valid  out  1  ciphertext available
i_ready  in  1  sink accepts the ciphertext
o_data  out  128  ciphertext
i_flush  in  1  synchronous abort of the operation in progress
o_busy  out  1  state != IDLE
o_key_req  out  1  subkey request (level)
o_key_idx  out  IDX_W  requested subkey index, 0..ROUNDS
i_key_valid  in  1  subkey valid; may assert in the same cycle as o_key_req
i_key  in  128  subkey
o_rf_data  out  128  round-function input: state ^ i_key
o_rf_round  out  IDX_W  round-function round index
i_rf_data  in  128  round-function output, combinational from o_rf_data

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE, round counter=0, state register=0.
  - o_ready=0 while in reset, then 1 once IDLE is active.
  - o_valid=0, o_busy=0, o_key_req=0, o_key_idx=0, o_data=0.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid: state register <= i_data, counter <= 0, go to ROUND.
- ROUND:
  - o_key_req=1, o_key_idx=counter, o_rf_round=counter.
  - o_rf_data = state register ^ i_key at all times; only meaningful while i_key_valid.
  - On i_key_valid: state register <= i_rf_data.
  - If counter==ROUNDS-1, go to FINAL; else counter <= counter+1.
  - Without i_key_valid: hold everything and keep o_key_req high (any wait length).
- FINAL:
  - o_key_req=1, o_key_idx=ROUNDS.
  - On i_key_valid: state register <= state register ^ i_key, go to DONE.
- DONE:
  - o_valid=1, o_data=state register, held stable until i_ready.
  - On i_ready: go to IDLE, o_valid drops the next cycle.
  - A new block is accepted only from IDLE; there is no overlap.
- Latency with zero-wait keys:
  - Accept edge E0.
  - Rounds 0..31 complete on edges E1..E32.
  - Final XOR on E33.
  - o_valid high in the cycle after E33, i.e. 33 cycles after accept.
  - Each key wait cycle adds one cycle.
- Ignored inputs:
  - i_key_valid while o_key_req=0 is ignored.
  - i_valid outside IDLE is ignored (o_ready=0).
- i_flush (any non-IDLE state): next state IDLE, counter=0, o_valid=0, o_key_req=0. The state register is not cleared.
  - i_flush has priority over i_key_valid and i_ready in the same cycle.
  - i_flush in IDLE blocks acceptance that cycle.
- Counter: IDLE-relative, never wraps; values stay 0..ROUNDS-1 in ROUND.
- Registered vs combinational outputs: o_ready, o_valid, o_busy, o_key_req and o_key_idx are decoded from registered state only (no combinational input-to-output paths). o_rf_data is the only combinational path (from i_key).
- Reset mid-operation: immediate return to the reset values. Any partial ciphertext is discarded.

Decomposition:
- Shared package serpent_pkg holds:
  - the FSM state encoding (IDLE/ROUND/FINAL/DONE);
  - SERPENT_ROUNDS=32;
  - BLOCK_W=128;
  - IDX_W=6.
- No sub-module is needed. The round function and the key schedule are sibling instances wired at the core top level.

Test Plan:
- Standard vector: key 0x00…00 (256-bit schedule stub), plaintext 0x00…00, zero-wait keys → o_valid 33 cycles after accept; o_data matches the reference-model ciphertext; o_key_idx sequence 0,1,…,32 with no gaps.
- Key stalls: i_key_valid withheld 3 cycles on rounds 0, 15 and 32 → same ciphertext, latency 42 cycles; o_key_idx stable throughout each stall.
- Output backpressure: i_ready low 10 cycles in DONE → o_valid and o_data held constant; o_ready stays 0; release → IDLE next cycle and o_ready=1.
- Flush at round 17 coincident with i_key_valid → IDLE next cycle, o_key_req=0, no o_valid; the next block encrypts correctly from round 0.
- Async reset asserted mid-ROUND (counter=9) between clock edges → all outputs at reset values immediately; after release, two back-to-back blocks (0x0123…CDEF, 0xFFFF…FFFF) encrypt correctly.
- i_valid held high continuously and stray i_key_valid pulses in IDLE/DONE → exactly one accept per IDLE visit; stray key pulses leave the state register unchanged.

Source files
------------

// File: rtl/serpent_pkg.sv
// Shared definitions for the iterative Serpent encryption sequencer.
// Holds the FSM state encoding and the block/round/index geometry.
package serpent_pkg;

  localparam int SERPENT_ROUNDS = 32;
  localparam int BLOCK_W        = 128;
  localparam int IDX_W          = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/serpent_round_ctrl.sv
// Iterative Serpent sequencer: owns the block state and round counter, mixes one subkey
// per round into the external round function, applies the whitening key and returns ciphertext.
module serpent_round_ctrl
  import serpent_pkg::*;
#(
  parameter int ROUNDS = SERPENT_ROUNDS,
  parameter int IDX_W  = serpent_pkg::IDX_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [BLOCK_W-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [BLOCK_W-1:0] o_data,
  input  logic               i_flush,
  output logic               o_busy,
  output logic               o_key_req,
  output logic [IDX_W-1:0]   o_key_idx,
  input  logic               i_key_valid,
  input  logic [BLOCK_W-1:0] i_key,
  output logic [BLOCK_W-1:0] o_rf_data,
  output logic [IDX_W-1:0]   o_rf_round,
  input  logic [BLOCK_W-1:0] i_rf_data
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ROUNDS - 1);
  localparam logic [IDX_W-1:0] FINAL_IDX = IDX_W'(ROUNDS);
  localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);

  state_e             r_state;
  logic [IDX_W-1:0]   r_cnt;
  logic [BLOCK_W-1:0] r_block;
  logic               r_ready;
  logic               r_valid;
  logic               r_busy;
  logic               r_key_req;
  logic [IDX_W-1:0]   r_key_idx;

  state_e             w_next_state;
  logic [IDX_W-1:0]   w_next_cnt;
  logic [BLOCK_W-1:0] w_next_block;
  logic [IDX_W-1:0]   w_next_key_idx;

  // Next-state, counter and block-state update; flush outranks key and sink handshakes.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_block = r_block;
    case (r_state)
      ST_IDLE: begin
        if (i_flush) begin
          w_next_state = ST_IDLE;
        end else if (i_valid) begin
          w_next_block = i_data;
          w_next_cnt   = '0;
          w_next_state = ST_ROUND;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ROUND: begin
        if (i_flush) begin
          w_next_state = ST_IDLE;
          w_next_cnt   = '0;
        end else if (i_key_valid) begin
          w_next_block = i_rf_data;
          if (r_cnt == LAST_IDX) begin
            w_next_state = ST_FINAL;
          end else begin
            w_next_cnt = r_cnt + ONE_IDX;
          end
        end else begin
          w_next_state = ST_ROUND;
        end
      end
      ST_FINAL: begin
        if (i_flush) begin
          w_next_state = ST_IDLE;
          w_next_cnt   = '0;
        end else if (i_key_valid) begin
          w_next_block = r_block ^ i_key;
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_FINAL;
        end
      end
      ST_DONE: begin
        if (i_flush || i_ready) begin
          w_next_state = ST_IDLE;
          w_next_cnt   = '0;
        end else begin
          w_next_state = ST_DONE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Key index presented in the state being entered: the round number, or the whitening key.
  always_comb begin
    w_next_key_idx = '0;
    case (w_next_state)
      ST_ROUND: w_next_key_idx = w_next_cnt;
      ST_FINAL: w_next_key_idx = FINAL_IDX;
      default:  w_next_key_idx = '0;
    endcase
  end

  // Core state, counter and block register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_block <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_block <= w_next_block;
    end
  end

  // Handshake and key-request flags are flopped off the next state so no input reaches them combinationally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ready   <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_key_req <= 1'b0;
      r_key_idx <= '0;
    end else begin
      r_ready   <= (w_next_state == ST_IDLE);
      r_valid   <= (w_next_state == ST_DONE);
      r_busy    <= (w_next_state != ST_IDLE);
      r_key_req <= (w_next_state == ST_ROUND) || (w_next_state == ST_FINAL);
      r_key_idx <= w_next_key_idx;
    end
  end

  assign o_ready    = r_ready;
  assign o_valid    = r_valid;
  assign o_busy     = r_busy;
  assign o_key_req  = r_key_req;
  assign o_key_idx  = r_key_idx;
  assign o_data     = r_block;
  assign o_rf_round = r_cnt;
  // Only combinational path: valid whenever i_key carries the requested subkey.
  assign o_rf_data  = r_block ^ i_key;

endmodule

// File: tb/tb_serpent_round_ctrl.sv
// Self-checking bench for serpent_round_ctrl with a stub round function, a stub key
// schedule and a whole-block reference model.
module tb_serpent_round_ctrl;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [127:0] i_data;
  logic         o_valid;
  logic         i_ready;
  logic [127:0] o_data;
  logic         i_flush;
  logic         o_busy;
  logic         o_key_req;
  logic [5:0]   o_key_idx;
  logic         i_key_valid;
  logic [127:0] i_key;
  logic [127:0] o_rf_data;
  logic [5:0]   o_rf_round;
  logic [127:0] i_rf_data;

  logic [127:0] keys [0:32];
  int           stalls [0:32];
  int           n_checks = 0;
  int           n_fail   = 0;

  serpent_round_ctrl dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .i_flush     (i_flush),
    .o_busy      (o_busy),
    .o_key_req   (o_key_req),
    .o_key_idx   (o_key_idx),
    .i_key_valid (i_key_valid),
    .i_key       (i_key),
    .o_rf_data   (o_rf_data),
    .o_rf_round  (o_rf_round),
    .i_rf_data   (i_rf_data)
  );

  always #5 i_clk = ~i_clk;

  // Stand-in round function: nonlinear, round-dependent, purely combinational.
  function automatic logic [127:0] rf_fn(input logic [127:0] x, input logic [5:0] r);
    logic [127:0] y;
    logic [31:0]  rc;
    rc = 32'h9E3779B9 ^ {26'd0, r};
    y  = {x[116:0], x[127:117]} ^ (x & {x[0], x[127:1]}) ^ {x[63:0], x[127:64]};
    return y ^ {rc, 96'd0};
  endfunction

  // Whole encryption: 32 keyed rounds then whitening with the last key.
  function automatic logic [127:0] model(input logic [127:0] pt);
    logic [127:0] s;
    s = pt;
    for (int r = 0; r < 32; r++) s = rf_fn(s ^ keys[r], 6'(r));
    return s ^ keys[32];
  endfunction

  assign i_rf_data = rf_fn(o_rf_data, o_rf_round);

  always_comb begin
    i_key = '0;
    if (o_key_idx <= 6'd32) i_key = keys[o_key_idx];
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_keys(input bit zero);
    for (int k = 0; k <= 32; k++)
      keys[k] = zero ? 128'd0 : {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic clear_stalls();
    for (int k = 0; k <= 32; k++) stalls[k] = 0;
  endtask

  // Runs one block from a negedge in (or just after) IDLE; abort_kind 1 = flush, 2 = async reset.
  task automatic encrypt(input logic [127:0] pt, input int bp_cycles, input bit hold_valid,
                         input int abort_round, input int abort_kind);
    logic [127:0] exp_ct;
    int edges, idx_exp, left, exp_lat, guard;
    exp_ct  = model(pt);
    exp_lat = 33;
    for (int k = 0; k <= 32; k++) exp_lat += stalls[k];
    guard = 0;
    while (!o_ready && guard < 100) begin
      i_key_valid = 1'($urandom_range(0, 1));
      @(posedge i_clk); @(negedge i_clk);
      guard++;
    end
    check_eq("ready_before_accept", o_ready, 1);
    i_valid = 1'b1;
    i_data  = pt;
    i_key_valid = 1'($urandom_range(0, 1));
    @(posedge i_clk); @(negedge i_clk);
    if (hold_valid) i_data = ~pt;
    else i_valid = 1'b0;
    check_eq("busy_after_accept", o_busy, 1);
    check_eq("ready_while_busy", o_ready, 0);
    edges = 0; idx_exp = 0; left = stalls[0];
    while (!o_valid && edges < 400) begin
      check_eq("key_req", o_key_req, 1);
      check_eq("key_idx", o_key_idx, 128'(idx_exp));
      if (abort_kind == 1 && idx_exp == abort_round) begin
        i_flush = 1'b1; i_key_valid = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_flush = 1'b0; i_key_valid = 1'b0;
        check_eq("flush_key_req", o_key_req, 0);
        check_eq("flush_busy", o_busy, 0);
        check_eq("flush_ready", o_ready, 1);
        for (int c = 0; c < 4; c++) begin
          check_eq("flush_no_valid", o_valid, 0);
          @(posedge i_clk); @(negedge i_clk);
        end
        return;
      end
      if (abort_kind == 2 && idx_exp == abort_round) begin
        #2 i_rst = 1'b1;
        #1;
        check_eq("rst_ready", o_ready, 0);
        check_eq("rst_valid", o_valid, 0);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_key_req", o_key_req, 0);
        check_eq("rst_key_idx", o_key_idx, 0);
        check_eq("rst_data", o_data, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        i_valid = 1'b0;
        i_key_valid = 1'b0;
        return;
      end
      if (left > 0) begin
        i_key_valid = 1'b0;
        left--;
        @(posedge i_clk);
      end else begin
        i_key_valid = 1'b1;
        @(posedge i_clk);
        idx_exp++;
        left = (idx_exp <= 32) ? stalls[idx_exp] : 0;
      end
      edges++;
      @(negedge i_clk);
    end
    check_eq("latency", edges, exp_lat);
    check_eq("ciphertext", o_data, exp_ct);
    check_eq("done_key_req", o_key_req, 0);
    i_ready = 1'b0;
    for (int c = 0; c < bp_cycles; c++) begin
      i_key_valid = 1'($urandom_range(0, 1));
      @(posedge i_clk); @(negedge i_clk);
      check_eq("bp_valid", o_valid, 1);
      check_eq("bp_data", o_data, exp_ct);
      check_eq("bp_ready", o_ready, 0);
    end
    i_ready = 1'b1;
    i_key_valid = 1'($urandom_range(0, 1));
    @(posedge i_clk); @(negedge i_clk);
    i_ready = 1'b0;
    check_eq("release_valid", o_valid, 0);
    check_eq("release_ready", o_ready, 1);
    check_eq("release_busy", o_busy, 0);
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_ready = 1'b0;
    i_flush = 1'b0; i_key_valid = 1'b0;
    set_keys(1'b1);
    clear_stalls();
    #1;
    check_eq("reset_ready", o_ready, 0);
    check_eq("reset_valid", o_valid, 0);
    check_eq("reset_busy", o_busy, 0);
    check_eq("reset_key_req", o_key_req, 0);
    check_eq("reset_key_idx", o_key_idx, 0);
    check_eq("reset_data", o_data, 0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk); @(negedge i_clk);
    check_eq("idle_ready", o_ready, 1);

    // Standard all-zero vector, zero-wait keys.
    encrypt(128'd0, 0, 1'b0, -1, 0);

    // Key stalls on rounds 0, 15 and the whitening key.
    set_keys(1'b0);
    stalls[0] = 3; stalls[15] = 3; stalls[32] = 3;
    encrypt({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, -1, 0);
    clear_stalls();

    // Output backpressure.
    set_keys(1'b0);
    encrypt({$urandom, $urandom, $urandom, $urandom}, 10, 1'b0, -1, 0);

    // Flush at round 17 together with a key, then a clean block.
    set_keys(1'b0);
    encrypt({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 17, 1);
    encrypt({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, -1, 0);

    // Flush in IDLE blocks acceptance.
    i_valid = 1'b1; i_flush = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_valid = 1'b0; i_flush = 1'b0;
    check_eq("flush_idle_busy", o_busy, 0);
    check_eq("flush_idle_ready", o_ready, 1);

    // Async reset mid-round, then two back-to-back blocks.
    set_keys(1'b0);
    encrypt({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 9, 2);
    encrypt(128'h0123456789ABCDEF0123456789ABCDEF, 0, 1'b0, -1, 0);
    encrypt({128{1'b1}}, 0, 1'b0, -1, 0);

    // i_valid held high: one accept per IDLE visit.
    set_keys(1'b0);
    encrypt({$urandom, $urandom, $urandom, $urandom}, 2, 1'b1, -1, 0);
    encrypt({$urandom, $urandom, $urandom, $urandom}, 0, 1'b1, -1, 0);
    i_valid = 1'b0;

    // Randomized keys, stalls and backpressure.
    for (int b = 0; b < 4; b++) begin
      set_keys(1'b0);
      for (int k = 0; k <= 32; k++) stalls[k] = $urandom_range(0, 2);
      encrypt({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3), 1'b0, -1, 0);
    end
    clear_stalls();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
